// File: rtl/rvtu_valid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvtu_valid_pkg
// Description : Shared sizing, state and index types for the RVTU valid-bit
//               array controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rvtu_valid_pkg;

    localparam int ENTRIES = 128;
    localparam int IDX_W   = $clog2(ENTRIES);

    typedef enum logic [1:0] {INIT, RUN, FLUSH} rvtu_valid_state_e;

    typedef logic [IDX_W-1:0] rvtu_vidx_t;

endpackage : rvtu_valid_pkg
`default_nettype wire

// File: rtl/rvtu_valid_walker.sv
`default_nettype none
// ============================================================================
// Module      : rvtu_valid_walker
// Description : Clearing-walk counter shared by the INIT and FLUSH passes,
//               with terminal detect and end-of-flush done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rvtu_valid_walker
    import rvtu_valid_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_en,
    input  logic       i_flush,
    output rvtu_vidx_t o_cnt,
    output logic       o_last,
    output logic       o_done
);

    localparam rvtu_vidx_t c_last = rvtu_vidx_t'(ENTRIES - 1);

    rvtu_vidx_t r_cnt;
    logic       r_done;
    logic       w_last;

    assign w_last = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            // Only a requested flush reports completion; the power-up pass is silent.
            r_done <= i_en & i_flush & w_last;
            if (i_start) begin
                r_cnt <= '0;
            end else if (i_en) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;
    assign o_done = r_done;

endmodule : rvtu_valid_walker
`default_nettype wire

// File: rtl/rvtu_valid_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rvtu_valid_ctrl
// Description : Single-port arbiter for the RVTU valid-bit array: lookup,
//               fill, invalidate and full-array clearing walks.
// Revision    : 1.0 - initial release
// ============================================================================
module rvtu_valid_ctrl
    import rvtu_valid_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             lkp_valid,
    output logic             lkp_ready,
    input  logic [IDX_W-1:0] lkp_idx,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx,
    input  logic             fill_valid,
    output logic             fill_ready,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic             inv_valid,
    output logic             inv_ready,
    input  logic [IDX_W-1:0] inv_idx,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    output logic [IDX_W-1:0] va_addr,
    output logic             va_wdata,
    output logic             va_wen,
    input  logic             va_rdata
);

    rvtu_valid_state_e r_state;
    rvtu_valid_state_e w_state_nxt;
    rvtu_vidx_t        w_cnt;
    rvtu_vidx_t        r_rsp_idx;
    logic              r_rsp_valid;
    logic              w_last;
    logic              w_run;
    logic              w_walk;
    logic              w_lkp_acc;

    assign w_run  = (r_state == RUN);
    assign w_walk = (r_state == INIT) || (r_state == FLUSH);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (w_last)    w_state_nxt = RUN;
            RUN:     if (flush_req) w_state_nxt = FLUSH;
            FLUSH:   if (w_last)    w_state_nxt = RUN;
            default:                w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    rvtu_valid_walker u_walker (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_run & flush_req),
        .i_en    (w_walk),
        .i_flush (r_state == FLUSH),
        .o_cnt   (w_cnt),
        .o_last  (w_last),
        .o_done  (flush_done)
    );

    // Readies look only at higher-priority valids so no ready loops back on itself.
    assign inv_ready  = w_run & ~flush_req;
    assign fill_ready = w_run & ~flush_req & ~inv_valid;
    assign lkp_ready  = w_run & ~flush_req & ~inv_valid & ~fill_valid;
    assign flush_busy = w_walk;
    assign w_lkp_acc  = lkp_valid & lkp_ready;

    always_comb begin
        va_addr  = lkp_idx;
        va_wdata = 1'b0;
        va_wen   = 1'b0;
        if (w_walk) begin
            va_addr = w_cnt;
            va_wen  = 1'b1;
        end else if (!flush_req) begin
            if (inv_valid) begin
                va_addr = inv_idx;
                va_wen  = 1'b1;
            end else if (fill_valid) begin
                va_addr  = fill_idx;
                va_wdata = 1'b1;
                va_wen   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_idx   <= '0;
        end else begin
            r_rsp_valid <= w_lkp_acc;
            if (w_lkp_acc) begin
                r_rsp_idx <= lkp_idx;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_idx   = r_rsp_idx;
    assign rsp_hit   = va_rdata;

endmodule : rvtu_valid_ctrl
`default_nettype wire

// File: tb/tb_rvtu_valid_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvtu_valid_ctrl
// Description : Self-checking bench for rvtu_valid_ctrl with a valid-bit
//               array model and a per-cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rvtu_valid_ctrl;
    import rvtu_valid_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             lkp_valid = 1'b0, fill_valid = 1'b0, inv_valid = 1'b0, flush_req = 1'b0;
    logic [IDX_W-1:0] lkp_idx = '0, fill_idx = '0, inv_idx = '0;
    logic             lkp_ready, fill_ready, inv_ready;
    logic             rsp_valid, rsp_hit;
    logic [IDX_W-1:0] rsp_idx;
    logic             flush_busy, flush_done;
    logic [IDX_W-1:0] va_addr;
    logic             va_wdata, va_wen;
    logic             va_rdata = 1'b1;

    rvtu_valid_ctrl dut (
        .clk(clk), .rst(rst),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_idx(lkp_idx),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_idx(fill_idx),
        .inv_valid(inv_valid), .inv_ready(inv_ready), .inv_idx(inv_idx),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .va_addr(va_addr), .va_wdata(va_wdata), .va_wen(va_wen), .va_rdata(va_rdata)
    );

    always #5 clk = ~clk;

    // Valid-bit SRAM: one port, one-cycle read latency, powers up all ones.
    logic mem [ENTRIES];
    initial for (int i = 0; i < ENTRIES; i++) mem[i] = 1'b1;
    always @(posedge clk) begin
        if (va_wen === 1'b1) mem[va_addr] <= va_wdata;
        va_rdata <= mem[va_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: spec-level walk bookkeeping plus an ideal valid-bit set.
    bit m_known = 0;
    int m_walk_left = 0;
    int m_pos = 0;
    bit m_flush_walk = 0;
    bit m_done = 0;
    bit m_rsp_v = 0;
    int m_rsp_idx = 0;
    bit m_rsp_hit = 0;
    bit m_vb [ENTRIES];

    initial begin
        for (int i = 0; i < ENTRIES; i++) m_vb[i] = 1'b1;
        forever begin
            @(negedge clk);
            if (m_known) begin
                chk("flush_busy", flush_busy, m_walk_left > 0);
                chk("flush_done", flush_done, m_done);
                chk("rsp_valid", rsp_valid, m_rsp_v);
                if (m_rsp_v) begin
                    chk("rsp_idx", rsp_idx, m_rsp_idx);
                    chk("rsp_hit", rsp_hit, m_rsp_hit);
                end
                if (m_walk_left > 0) begin
                    chk("walk_wen", va_wen, 1);
                    chk("walk_wdata", va_wdata, 0);
                    chk("walk_addr", va_addr, m_pos);
                    chk("walk_readies", {inv_ready, fill_ready, lkp_ready}, 0);
                end else begin
                    chk("inv_ready", inv_ready, !flush_req);
                    chk("fill_ready", fill_ready, !flush_req && !inv_valid);
                    chk("lkp_ready", lkp_ready, !flush_req && !inv_valid && !fill_valid);
                    if (flush_req) chk("flush_wen", va_wen, 0);
                    else if (inv_valid) chk("inv_port", {va_wen, va_wdata, va_addr}, {2'b10, inv_idx});
                    else if (fill_valid) chk("fill_port", {va_wen, va_wdata, va_addr}, {2'b11, fill_idx});
                    else if (lkp_valid) chk("lkp_port", {va_wen, va_addr}, {1'b0, lkp_idx});
                    else chk("idle_wen", va_wen, 0);
                end
            end
            if (rst !== 1'b1) begin
                m_known = 1; m_walk_left = ENTRIES; m_pos = 0; m_flush_walk = 0;
                m_done = 0; m_rsp_v = 0;
            end else if (m_walk_left > 0) begin
                m_vb[m_pos] = 1'b0;
                m_pos++;
                m_walk_left--;
                m_done = (m_walk_left == 0) && m_flush_walk;
                m_rsp_v = 0;
            end else begin
                m_done = 0;
                m_rsp_v = 0;
                if (flush_req) begin
                    m_walk_left = ENTRIES; m_pos = 0; m_flush_walk = 1;
                end else if (inv_valid) m_vb[inv_idx] = 1'b0;
                else if (fill_valid) m_vb[fill_idx] = 1'b1;
                else if (lkp_valid) begin
                    m_rsp_v = 1; m_rsp_idx = int'(lkp_idx); m_rsp_hit = m_vb[lkp_idx];
                end
            end
        end
    end

    typedef struct { int c; int idx; bit hit; } rsp_t;
    rsp_t log_q[$];
    initial forever begin
        rsp_t e;
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
            e.c = cyc; e.idx = int'(rsp_idx); e.hit = rsp_hit;
            log_q.push_back(e);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input string name, input int k, input int idx, input bit hit, input bit consec);
        chk({name, "_present"}, log_q.size() > k, 1);
        if (log_q.size() > k) begin
            chk({name, "_idx"}, log_q[k].idx, idx);
            chk({name, "_hit"}, log_q[k].hit, hit);
            if (consec && k > 0) chk({name, "_consec"}, log_q[k].c - log_q[k-1].c, 1);
        end
    endtask

    // Present a set of requests and hold each until accepted; returns acceptance cycles.
    task automatic hold_reqs(input bit iv, input int ii, input bit fv, input int fi,
                             input bit lv, input int li, output int c_inv, output int c_fill, output int c_lkp);
        bit ai, af, al;
        c_inv = -1; c_fill = -1; c_lkp = -1;
        inv_valid = iv;  inv_idx  = rvtu_vidx_t'(ii);
        fill_valid = fv; fill_idx = rvtu_vidx_t'(fi);
        lkp_valid = lv;  lkp_idx  = rvtu_vidx_t'(li);
        for (int k = 0; k < 20 && (inv_valid || fill_valid || lkp_valid); k++) begin
            @(negedge clk);
            ai = inv_valid && inv_ready === 1'b1;
            af = fill_valid && fill_ready === 1'b1;
            al = lkp_valid && lkp_ready === 1'b1;
            if (ai) c_inv = cyc;
            if (af) c_fill = cyc;
            if (al) c_lkp = cyc;
            step();
            if (ai) inv_valid = 1'b0;
            if (af) fill_valid = 1'b0;
            if (al) lkp_valid = 1'b0;
        end
        if (inv_valid || fill_valid || lkp_valid) begin
            chk("handshake_timeout", 1, 0);
            inv_valid = 1'b0; fill_valid = 1'b0; lkp_valid = 1'b0;
        end
    endtask

    task automatic do_fill(input int idx);
        int a, b, c;
        hold_reqs(0, 0, 1, idx, 0, 0, a, b, c);
    endtask

    task automatic lkp_burst(input int first, input int n);
        lkp_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            lkp_idx = rvtu_vidx_t'(first + i);
            step();
        end
        lkp_valid = 1'b0;
        repeat (3) step();
    endtask

    // Pulse flush_req for one RUN cycle and return that cycle number.
    task automatic pulse_flush(output int fcyc);
        flush_req = 1'b1;
        @(negedge clk);
        fcyc = cyc;
        step();
        flush_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, ci, cf, cl, fcyc, busy_n, done_n, done_c, rsp_n;
        bit brk;

        // Reset release and power-up walk; a held lookup must wait it out.
        repeat (3) step();
        lkp_valid = 1'b1; lkp_idx = '0;
        rst = 1'b1;
        n = 0; brk = 0;
        for (int k = 0; k < 300 && !brk; k++) begin
            @(negedge clk);
            if (flush_busy === 1'b1) begin
                chk("init_addr_seq", va_addr, k);
                n++;
                @(posedge clk);
            end else brk = 1;
        end
        chk("init_walk_len", n, 128);
        chk("run_busy", flush_busy, 0);
        chk("run_lkp_ready", lkp_ready, 1);
        step();
        lkp_valid = 1'b0;
        repeat (3) step();

        // Fill 5, then back-to-back lookups of 5 and 6.
        log_q.delete();
        do_fill(5);
        lkp_burst(5, 2);
        chk("t2_count", log_q.size(), 2);
        expect_rsp("t2_r0", 0, 5, 1, 0);
        expect_rsp("t2_r1", 1, 6, 0, 1);

        // Simultaneous inv 5 / fill 9 / lkp 9 drain in priority order.
        log_q.delete();
        hold_reqs(1, 5, 1, 9, 1, 9, ci, cf, cl);
        chk("t3_fill_after_inv", cf - ci, 1);
        chk("t3_lkp_after_fill", cl - cf, 1);
        lkp_burst(5, 1);
        chk("t3_count", log_q.size(), 2);
        expect_rsp("t3_r0", 0, 9, 1, 0);
        expect_rsp("t3_r1", 1, 5, 0, 0);

        // Flush with a redundant flush_req mid-walk.
        do_fill(3); do_fill(64); do_fill(127);
        pulse_flush(fcyc);
        busy_n = 0; done_n = 0; done_c = -1;
        for (int k = 0; k < 300; k++) begin
            flush_req = (k == 50);
            @(negedge clk);
            if (flush_busy === 1'b1) busy_n++;
            if (flush_done === 1'b1) begin done_n++; done_c = cyc; end
            step();
        end
        flush_req = 1'b0;
        chk("t4_walk_len", busy_n, 128);
        chk("t4_done_count", done_n, 1);
        chk("t4_done_latency", done_c - fcyc, 129);
        log_q.delete();
        lkp_valid = 1'b1;
        lkp_idx = 7'd3;   step();
        lkp_idx = 7'd64;  step();
        lkp_idx = 7'd127; step();
        lkp_valid = 1'b0;
        repeat (3) step();
        chk("t4_count", log_q.size(), 3);
        expect_rsp("t4_r0", 0, 3, 0, 0);
        expect_rsp("t4_r1", 1, 64, 0, 1);
        expect_rsp("t4_r2", 2, 127, 0, 1);

        // Reset at walk count 40 of a flush.
        pulse_flush(fcyc);
        busy_n = 0; done_n = 0; rsp_n = 0;
        for (int k = 0; k < 250; k++) begin
            if (k == 40) rst = 1'b0;
            if (k == 42) rst = 1'b1;
            @(negedge clk);
            if (k == 40) chk("t5_count_at_reset", va_addr, 40);
            if (k == 42) chk("t5_restart_addr", va_addr, 0);
            if (k >= 42 && flush_busy === 1'b1) busy_n++;
            if (flush_done === 1'b1) done_n++;
            if (rsp_valid === 1'b1) rsp_n++;
            step();
        end
        chk("t5_walk_len", busy_n, 128);
        chk("t5_no_done", done_n, 0);
        chk("t5_no_rsp", rsp_n, 0);

        // Even entries valid; eight back-to-back lookups.
        for (int i = 0; i < 8; i += 2) do_fill(i);
        log_q.delete();
        lkp_burst(0, 8);
        chk("t6_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++) expect_rsp("t6_r", i, i, (i % 2) == 0, 1);

        // A lookup in the same cycle as reset assertion is dropped.
        log_q.delete();
        lkp_valid = 1'b1; lkp_idx = 7'd2; rst = 1'b0;
        step();
        lkp_valid = 1'b0;
        step();
        rst = 1'b1;
        repeat (135) step();
        chk("t7_no_rsp", log_q.size(), 0);
        chk("t7_back_in_run", flush_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rvtu_valid_ctrl
`default_nettype wire
